// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one input bit per clock).
// Results and decimal-point enables are held stable between conversions.
module bin_to_bcd_seq #(
    parameter int BIN_W   = 14,
    parameter int MAX_VAL = 9999
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [BIN_W-1:0] i_bin_in,
    input  logic             i_dp_en,
    input  logic [1:0]       i_dp_pos,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_overflow,
    output logic [3:0]       o_data0,
    output logic [3:0]       o_data1,
    output logic [3:0]       o_data2,
    output logic [3:0]       o_data3,
    output logic [3:0]       o_dp_out
);
    localparam int                ITER_W = $clog2(BIN_W + 1);
    localparam logic [31:0]       MAX_U  = 32'(MAX_VAL);
    localparam logic [ITER_W-1:0] LAST   = ITER_W'(BIN_W - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            r_state, w_state_nxt;
    logic [15:0]       r_acc, w_acc_nxt, w_acc_adj, w_acc_sh;
    logic [BIN_W-1:0]  r_bin, w_bin_nxt, w_bin_sh;
    logic [ITER_W-1:0] r_iter, w_iter_nxt;
    logic              r_ovf_pend, w_ovf_pend_nxt;
    logic              r_dp_en, w_dp_en_nxt;
    logic [1:0]        r_dp_pos, w_dp_pos_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic              r_ovf, w_ovf_nxt;
    logic [15:0]       r_data, w_data_nxt;
    logic [3:0]        r_dp, w_dp_nxt;
    logic              w_in_ovf;

    assign w_in_ovf = 32'(i_bin_in) > MAX_U;

    // Add-3 per nibble with no inter-nibble carry, then shift {acc, bin} left.
    always_comb begin
        w_acc_adj = r_acc;
        for (int n = 0; n < 4; n++) begin
            if (r_acc[4*n +: 4] >= 4'd5)
                w_acc_adj[4*n +: 4] = r_acc[4*n +: 4] + 4'd3;
        end
        w_acc_sh = {w_acc_adj[14:0], r_bin[BIN_W-1]};
        w_bin_sh = r_bin << 1;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_acc_nxt      = r_acc;
        w_bin_nxt      = r_bin;
        w_iter_nxt     = r_iter;
        w_ovf_pend_nxt = r_ovf_pend;
        w_dp_en_nxt    = r_dp_en;
        w_dp_pos_nxt   = r_dp_pos;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_ovf_nxt      = r_ovf;
        w_data_nxt     = r_data;
        w_dp_nxt       = r_dp;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_bin_nxt      = i_bin_in;
                    w_dp_en_nxt    = i_dp_en;
                    w_dp_pos_nxt   = i_dp_pos;
                    w_acc_nxt      = '0;
                    w_iter_nxt     = '0;
                    w_ovf_pend_nxt = w_in_ovf;
                    w_busy_nxt     = 1'b1;
                    w_state_nxt    = SHIFT;
                end
            end
            SHIFT: begin
                w_acc_nxt  = w_acc_sh;
                w_bin_nxt  = w_bin_sh;
                w_iter_nxt = r_iter + 1'b1;
                if (r_iter == LAST) begin
                    w_data_nxt = r_ovf_pend ? 16'hEEEE : w_acc_sh;
                    w_ovf_nxt  = r_ovf_pend;
                    for (int i = 0; i < 4; i++)
                        w_dp_nxt[i] = !(r_dp_en && (r_dp_pos == 2'(i)) && !r_ovf_pend);
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_acc      <= '0;
            r_bin      <= '0;
            r_iter     <= '0;
            r_ovf_pend <= 1'b0;
            r_dp_en    <= 1'b0;
            r_dp_pos   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
            r_data     <= '0;
            r_dp       <= 4'b1111;
        end else begin
            r_state    <= w_state_nxt;
            r_acc      <= w_acc_nxt;
            r_bin      <= w_bin_nxt;
            r_iter     <= w_iter_nxt;
            r_ovf_pend <= w_ovf_pend_nxt;
            r_dp_en    <= w_dp_en_nxt;
            r_dp_pos   <= w_dp_pos_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_ovf      <= w_ovf_nxt;
            r_data     <= w_data_nxt;
            r_dp       <= w_dp_nxt;
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_overflow = r_ovf;
    assign o_data0    = r_data[3:0];
    assign o_data1    = r_data[7:4];
    assign o_data2    = r_data[11:8];
    assign o_data3    = r_data[15:12];
    assign o_dp_out   = r_dp;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed cases plus random values
// compared against a decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;
    localparam int BIN_W   = 14;
    localparam int MAX_VAL = 9999;

    logic             clk = 1'b0;
    logic             rst, start, dp_en;
    logic [BIN_W-1:0] bin_in;
    logic [1:0]       dp_pos;
    logic             busy, done, overflow;
    logic [3:0]       data0, data1, data2, data3, dp_out;

    bin_to_bcd_seq #(.BIN_W(BIN_W), .MAX_VAL(MAX_VAL)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_bin_in(bin_in),
        .i_dp_en(dp_en), .i_dp_pos(dp_pos), .o_busy(busy), .o_done(done),
        .o_overflow(overflow), .o_data0(data0), .o_data1(data1),
        .o_data2(data2), .o_data3(data3), .o_dp_out(dp_out)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [15:0] exp_data = 16'h0;
    logic [3:0]  exp_dp   = 4'hF;
    logic        exp_ovf  = 1'b0;
    logic [15:0] pend_data;
    logic [3:0]  pend_dp;
    logic        pend_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_outs(input string tag);
        chk({tag, ".data"}, {data3, data2, data1, data0}, exp_data);
        chk({tag, ".dp"}, dp_out, exp_dp);
        chk({tag, ".ovf"}, overflow, exp_ovf);
    endtask

    function automatic logic [15:0] ref_digits(input int v);
        if (v > MAX_VAL) return 16'hEEEE;
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Present a request at a negedge; the next posedge accepts it.
    task automatic set_req(input int v, input bit de, input int pos);
        logic [3:0] one;
        one       = 4'b0001;
        start     = 1'b1;
        bin_in    = BIN_W'(v);
        dp_en     = de;
        dp_pos    = 2'(pos);
        pend_data = ref_digits(v);
        pend_ovf  = (v > MAX_VAL);
        pend_dp   = (de && !pend_ovf) ? ~(one << pos) : 4'hF;
    endtask

    // Waits for done (bounded), checking hold/busy every cycle and latency at the end.
    // Returns at the negedge where done is high.
    task automatic wait_done(input string tag, input int hold_start);
        int  lat;
        bit  seen;
        seen = 0;
        for (lat = 1; lat <= 40; lat++) begin
            @(negedge clk);
            if (lat >= hold_start) start = 1'b0;
            bin_in = BIN_W'($urandom);
            dp_en  = 1'($urandom);
            dp_pos = 2'($urandom);
            if (done) begin
                seen = 1;
                break;
            end
            chk({tag, ".hold"}, {data3, data2, data1, data0}, exp_data);
            chk({tag, ".busy"}, busy, 1'b1);
        end
        if (!seen) begin
            chk({tag, ".timeout"}, 0, 1);
        end else begin
            chk({tag, ".latency"}, lat, BIN_W + 1);
            exp_data = pend_data;
            exp_dp   = pend_dp;
            exp_ovf  = pend_ovf;
            chk_outs(tag);
            chk({tag, ".busy_done"}, busy, 1'b0);
        end
    endtask

    task automatic conv(input string tag, input int v, input bit de, input int pos);
        @(negedge clk);
        set_req(v, de, pos);
        wait_done(tag, 1);
        start = 1'b0;
        @(negedge clk);
        chk({tag, ".pulse"}, done, 1'b0);
    endtask

    initial begin
        int dn;
        rst = 1'b1; start = 1'b0; bin_in = '0; dp_en = 1'b0; dp_pos = '0;
        repeat (2) @(negedge clk);
        chk_outs("reset");
        chk("reset.busy", busy, 1'b0);
        chk("reset.done", done, 1'b0);
        rst = 1'b0;

        conv("t1234", 1234, 1'b1, 2);
        chk("t1234.dp_lit", dp_out, 4'b1011);

        // back-to-back: second request presented while done is high
        @(negedge clk);
        set_req(9999, 1'b0, 0);
        wait_done("t9999", 1);
        set_req(0, 1'b1, 0);
        wait_done("t0_b2b", 1);
        start = 1'b0;
        @(negedge clk);
        chk("t0_b2b.pulse", done, 1'b0);

        conv("t10000", 10000, 1'b1, 1);
        conv("t42", 42, 1'b0, 0);

        // start held across the first cycles of a conversion
        @(negedge clk);
        set_req(567, 1'b1, 3);
        wait_done("t567", 6);
        start = 1'b0;
        dn = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("t567.extra_done", dn, 0);
        chk("t567.idle", busy, 1'b0);

        // reset mid-conversion
        conv("pre1234", 1234, 1'b0, 0);
        set_req(8888, 1'b1, 0);
        repeat (8) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("abort.busy_before", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_data = 16'h0; exp_dp = 4'hF; exp_ovf = 1'b0;
        chk_outs("abort");
        chk("abort.busy", busy, 1'b0);
        dn = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("abort.no_done", dn, 0);
        conv("t8888", 8888, 1'b1, 0);

        // boundaries and random values
        conv("b16383", 16383, 1'b1, 2);
        conv("b10000", 10000, 1'b0, 0);
        conv("b9999", 9999, 1'b1, 3);
        for (int i = 0; i < 40; i++) begin
            int v;
            v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(MAX_VAL + 1, (1 << BIN_W) - 1))
                                            : int'($urandom_range(0, MAX_VAL));
            @(negedge clk);
            set_req(v, 1'($urandom), int'($urandom_range(0, 3)));
            wait_done("rand", 1);
            if ($urandom_range(0, 1) == 1) begin
                set_req(int'($urandom_range(0, (1 << BIN_W) - 1)), 1'($urandom),
                        int'($urandom_range(0, 3)));
                wait_done("rand_b2b", 1);
            end
            start = 1'b0;
            @(negedge clk);
            chk("rand.pulse", done, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
